// File: rtl/load_store_unit.sv
// Data-memory access stage: aligns a single load or store onto a valid/ack bus,
// then returns one response carrying extended load data or an error code.
//
// state | meaning
// IDLE  | ready for a request; decode and error checks happen on accept
// BUS   | mem_req held with registered address/strobes/data until ack or timeout
// RESP  | one-cycle resp_valid pulse, then back to IDLE
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign req_ready = (state == IDLE);
  assign cnt_inc   = cnt + 32'd1;

  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_store;
      default:                illegal = 1'b1;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    strb      = 4'b1111;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        strb      = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb      = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // Lane selection uses the offset latched at accept; mem_addr itself is word-aligned.
  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      cnt        <= 32'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            cnt     <= 32'd0;
            if (illegal || misaligned) begin
              resp_valid <= 1'b1;
              resp_rdata <= 32'd0;
              resp_err   <= illegal ? 2'b11 : 2'b01;
              state      <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_store ? strb : 4'd0;
              mem_wdata <= req_store ? wdata_rep : 32'd0;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack || ((TIMEOUT_CYCLES != 0) && (cnt_inc == 32'(TIMEOUT_CYCLES)))) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wstrb  <= 4'd0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b1;
            resp_rdata <= (mem_ack && !store_q) ? load_ext : 32'd0;
            resp_err   <= mem_ack ? 2'b00 : 2'b10;
            state      <= RESP;
          end
          if (!mem_ack) cnt <= cnt_inc;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
